data_mem_responder: RTL

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, commits stores with byte/half/word lane enables, and returns right-justified load data or an error over a second valid/ready handshake. It replaces the zero-latency data memory behind the MEM stage so the pipeline can be exercised against realistic memory latency and back-pressure.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared size encodings, FSM state type and limits for the
//                data-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Access size encoding, identical to store funct3[1:0]
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Largest supported number of wait states (fits the 3-bit counter)
    localparam int WAIT_STATES_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational lane decode: byte enables, lane-placed store
//                data and misalignment / reserved-size flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_aligned,
    output logic        misaligned
);

    // Replicating the low data bits puts them in every candidate lane; the
    // byte enables then pick the lanes that are actually written.
    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = 32'd0;
        misaligned    = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_aligned = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                misaligned    = addr_lo[0];
            end
            SIZE_WORD: begin
                byte_en       = 4'b1111;
                wdata_aligned = wdata;
                misaligned    = (addr_lo != 2'b00);
            end
            default: begin
                misaligned    = 1'b1;
            end
        endcase
        if (misaligned) begin
            byte_en = 4'b0000;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-outstanding load/store responder with programmable
//                wait states, byte/half/word lanes and error reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int         c_words     = 2 ** ADDR_WIDTH;
    localparam int         c_ws        = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [2:0] c_wait_init = (c_ws > 0) ? 3'(c_ws - 1) : 3'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic [31:0] r_mem [c_words];

    logic        w_in_idle;
    logic        w_accept;
    logic        w_access;
    logic        w_acc_write;
    logic [31:0] w_acc_addr;
    logic [1:0]  w_acc_size;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_al;
    logic        w_misaligned;
    logic        w_range_err;
    logic        w_error;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [31:0] w_rd_shift;
    logic [31:0] w_rd_data;
    logic [31:0] w_rsp_data;
    logic        w_mem_we;

    assign w_in_idle = (r_state == IDLE);
    assign w_accept  = w_in_idle && req_valid;

    // With no wait states the access happens on the acceptance edge itself,
    // so the live request feeds the datapath while idle; otherwise the
    // captured copy does.
    assign w_acc_write = w_in_idle ? req_write : r_write;
    assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
    assign w_acc_size  = w_in_idle ? req_size  : r_size;
    assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;

    assign w_access = (w_accept && (c_ws == 0)) || ((r_state == WAIT) && (r_cnt == 3'd0));

    dmem_lane_align u_lane_align (
        .size          (w_acc_size),
        .addr_lo       (w_acc_addr[1:0]),
        .wdata         (w_acc_wdata),
        .byte_en       (w_be),
        .wdata_aligned (w_wdata_al),
        .misaligned    (w_misaligned)
    );

    assign w_range_err = ((w_acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_error     = w_misaligned || w_range_err;
    assign w_word_idx  = w_acc_addr[ADDR_WIDTH+1:2];
    assign w_rd_shift  = r_mem[w_word_idx] >> {w_acc_addr[1:0], 3'b000};

    // Right-justify and zero-fill the load data above the access size
    always_comb begin
        w_rd_data = w_rd_shift;
        case (w_acc_size)
            SIZE_BYTE: w_rd_data = {24'd0, w_rd_shift[7:0]};
            SIZE_HALF: w_rd_data = {16'd0, w_rd_shift[15:0]};
            default:   w_rd_data = w_rd_shift;
        endcase
    end

    assign w_rsp_data = (w_acc_write || w_error) ? 32'd0 : w_rd_data;
    // Gating with resetn keeps a clock edge during reset from committing a store
    assign w_mem_we   = w_access && w_acc_write && !w_error && resetn;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)      w_state_next = (c_ws == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 3'd0)  w_state_next = RESP;
            RESP:    if (rsp_ready)      w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
    end

    // Request capture, wait counter and registered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= 3'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_size      <= 2'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_size  <= req_size;
                r_wdata <= req_wdata;
                r_cnt   <= c_wait_init;
            end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
                r_cnt   <= r_cnt - 3'd1;
            end

            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= w_error;
                r_rsp_rdata <= w_rsp_data;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_error <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

    // Word array with per-lane write enables; contents are not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = w_in_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire
